// File: rtl/byte_word_packer_pkg.sv
// byte_word_packer_pkg: shared types and default sizes for the byte-to-word packer
package byte_word_packer_pkg;
  localparam int DEF_IN_W = 8;
  localparam int DEF_LANES = 4;
  localparam int CNT_W = 16;
  typedef enum logic [1:0] {IDLE, FILL, HOLD} packer_state_t;
endpackage

// File: rtl/byte_word_packer_if.sv
// byte_word_packer_if: byte-in / word-out handshake bundle
// slave  = packer side: data_in/valid_in/last_in/ready_out in; ready_in, data_out/keep_out/last_out/valid_out, word_cnt out
// master = producer/consumer side, opposite directions
// parity_out exists only when BYTE_WORD_PACKER_PARITY_EN is defined
interface byte_word_packer_if
  import byte_word_packer_pkg::*;
#(
  parameter int IN_W = DEF_IN_W,
  parameter int LANES = DEF_LANES
);
  logic [IN_W-1:0] data_in;
  logic valid_in;
  logic last_in;
  logic ready_in;
  logic [IN_W*LANES-1:0] data_out;
  logic [LANES-1:0] keep_out;
  logic last_out;
  logic valid_out;
  logic ready_out;
  logic [CNT_W-1:0] word_cnt;
`ifdef BYTE_WORD_PACKER_PARITY_EN
  logic [LANES-1:0] parity_out;
  modport slave (input data_in, valid_in, last_in, ready_out,
                 output ready_in, data_out, keep_out, last_out, valid_out, word_cnt, parity_out);
  modport master (output data_in, valid_in, last_in, ready_out,
                  input ready_in, data_out, keep_out, last_out, valid_out, word_cnt, parity_out);
`else
  modport slave (input data_in, valid_in, last_in, ready_out,
                 output ready_in, data_out, keep_out, last_out, valid_out, word_cnt);
  modport master (output data_in, valid_in, last_in, ready_out,
                  input ready_in, data_out, keep_out, last_out, valid_out, word_cnt);
`endif
endinterface

// File: rtl/byte_word_packer_parity_gen.sv
// packer_parity_gen: per-lane even parity, forced to 0 on lanes without a real byte
// data: packed lanes in; keep: lane-valid flags in; parity: masked lane parity out
module packer_parity_gen #(
  parameter int IN_W = 8,
  parameter int LANES = 4
) (
  input  logic [LANES-1:0][IN_W-1:0] data,
  input  logic [LANES-1:0] keep,
  output logic [LANES-1:0] parity
);
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign parity[i] = keep[i] & ^data[i];
  end
endmodule

// File: rtl/byte_word_packer.sv
// byte_word_packer: packs an IN_W-bit byte stream into LANES-lane words with keep/last flags
// clk, rst (async, active-high); bus (slave modport): byte handshake in, word handshake out, word_cnt
// BYTE_WORD_PACKER_PARITY_EN adds per-lane parity_out latched with the word
module byte_word_packer
  import byte_word_packer_pkg::*;
#(
  parameter int IN_W = DEF_IN_W,
  parameter int LANES = DEF_LANES
) (
  input logic clk,
  input logic rst,
  byte_word_packer_if.slave bus
);
  localparam int IW = $clog2(LANES);
  localparam logic [IW-1:0] LAST_LANE = IW'(LANES - 1);
  packer_state_t state;
  logic [IW-1:0] idx;
  logic [LANES-1:0][IN_W-1:0] data_q;
  logic [LANES-1:0] keep_q;
  logic last_q;
  logic [CNT_W-1:0] cnt_q;
  logic byte_xfer, word_xfer, start, close;
  assign bus.ready_in = state != HOLD || bus.ready_out;
  assign byte_xfer = bus.valid_in && bus.ready_in;
  assign word_xfer = state == HOLD && bus.ready_out;
  // a byte outside FILL always begins a fresh word (from IDLE, or alongside a word hand-off)
  assign start = byte_xfer && state != FILL;
  assign close = bus.last_in || idx == LAST_LANE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      data_q <= '0;
      keep_q <= '0;
      last_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (word_xfer) cnt_q <= cnt_q + 1'b1;
      if (start) begin
        data_q <= (IN_W*LANES)'(bus.data_in);
        keep_q <= LANES'(1);
        last_q <= bus.last_in;
        state <= bus.last_in ? HOLD : FILL;
        idx <= bus.last_in ? '0 : IW'(1);
      end else if (byte_xfer) begin
        data_q[idx] <= bus.data_in;
        keep_q[idx] <= 1'b1;
        last_q <= bus.last_in;
        state <= close ? HOLD : FILL;
        idx <= close ? '0 : idx + 1'b1;
      end else if (word_xfer) state <= IDLE;
    end
  assign bus.valid_out = state == HOLD;
  assign bus.data_out = data_q;
  assign bus.keep_out = keep_q;
  assign bus.last_out = last_q;
  assign bus.word_cnt = cnt_q;
`ifdef BYTE_WORD_PACKER_PARITY_EN
  packer_parity_gen #(.IN_W(IN_W), .LANES(LANES)) u_parity (
    .data(data_q),
    .keep(keep_q),
    .parity(bus.parity_out)
  );
`endif
endmodule

// File: tb/tb_byte_word_packer.sv
// tb_byte_word_packer: random and directed stimulus checked against a frame-level reference model
module tb_byte_word_packer;
  typedef struct {
    logic [31:0] d;
    logic [3:0] k;
    logic l;
  } word_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  word_t q[$];
  logic [31:0] part_d = '0;
  int part_n = 0;
  logic [15:0] exp_cnt = '0;
  logic bx;
  byte_word_packer_if #(.IN_W(8), .LANES(4)) bus ();
  byte_word_packer #(.IN_W(8), .LANES(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [3:0] par(input word_t w);
    par = '0;
    for (int i = 0; i < 4; i++) par[i] = w.k[i] & ^w.d[i*8+:8];
  endfunction
  task automatic model_byte(input logic [7:0] d, input logic l);
    word_t w;
    part_d[part_n*8+:8] = d;
    part_n++;
    if (l || part_n == 4) begin
      w.d = part_d;
      w.k = 4'((1 << part_n) - 1);
      w.l = l;
      q.push_back(w);
      part_d = '0;
      part_n = 0;
    end
  endtask
  task automatic model_clear();
    q.delete();
    part_d = '0;
    part_n = 0;
    exp_cnt = '0;
  endtask
  task automatic step(input logic v, input logic [7:0] d, input logic l, input logic ro, output logic b);
    word_t w;
    logic wx;
    @(negedge clk);
    bus.valid_in = v;
    bus.data_in = d;
    bus.last_in = l;
    bus.ready_out = ro;
    #1;
    check("valid_out", 32'(bus.valid_out), 32'(q.size() != 0));
    check("ready_in", 32'(bus.ready_in), 32'(q.size() == 0 || ro));
    b = v && bus.ready_in;
    wx = bus.valid_out && ro;
    if (bus.valid_out && q.size() != 0) begin
      w = q[0];
      check("data_out", bus.data_out, w.d);
      check("keep_out", 32'(bus.keep_out), 32'(w.k));
      check("last_out", 32'(bus.last_out), 32'(w.l));
`ifdef BYTE_WORD_PACKER_PARITY_EN
      check("parity_out", 32'(bus.parity_out), 32'(par(w)));
`endif
    end
    if (wx && q.size() != 0) begin
      w = q.pop_front();
      exp_cnt++;
    end
    if (b) model_byte(d, l);
    @(posedge clk);
    #1 check("word_cnt", 32'(bus.word_cnt), 32'(exp_cnt));
  endtask
  initial begin
    int i, n;
    bus.valid_in = 1'b0;
    bus.data_in = '0;
    bus.last_in = 1'b0;
    bus.ready_out = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(bus.valid_out), 0);
    check("rst_data", bus.data_out, 0);
    check("rst_keep", 32'(bus.keep_out), 0);
    check("rst_last", 32'(bus.last_out), 0);
    check("rst_cnt", 32'(bus.word_cnt), 0);
    check("rst_ready_in", 32'(bus.ready_in), 1);
    rst = 1'b0;
    step(1, 8'h11, 0, 1, bx);
    step(1, 8'h22, 0, 1, bx);
    step(1, 8'h33, 0, 1, bx);
    step(1, 8'h44, 0, 1, bx);
    check("t1_data", bus.data_out, 32'h44332211);
    check("t1_keep", 32'(bus.keep_out), 32'hf);
    step(0, 8'h00, 0, 1, bx);
    check("t1_cnt", 32'(bus.word_cnt), 1);
    step(1, 8'hA1, 0, 1, bx);
    step(1, 8'hA2, 1, 1, bx);
    check("t2_data", bus.data_out, 32'h0000A2A1);
    check("t2_keep", 32'(bus.keep_out), 32'h3);
    check("t2_last", 32'(bus.last_out), 1);
    step(0, 8'h00, 0, 1, bx);
    for (int j = 0; j < 4; j++) step(1, 8'(8'hC0 + j), 0, 0, bx);
    repeat (5) step(1, 8'h55, 0, 0, bx);
    step(1, 8'h55, 0, 1, bx);
    check("t3_accept55", 32'(bx), 1);
    step(1, 8'h66, 1, 1, bx);
    check("t3_next_word", bus.data_out, 32'h00006655);
    step(0, 8'h00, 0, 1, bx);
    i = 0;
    n = 0;
    while (i < 9 && n < 300) begin
      step(1, 8'(i + 1), i == 8, 1'($urandom_range(0, 1)), bx);
      if (bx) i++;
      n++;
    end
    check("t4_all_bytes", 32'(i), 9);
    repeat (3) step(0, 8'h00, 0, 1, bx);
    check("t4_drained", 32'(q.size()), 0);
    repeat (300) step(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0, bx);
    step(1, 8'hEE, 1, 1, bx);
    repeat (2) step(0, 8'h00, 0, 1, bx);
    step(1, 8'hB8, 0, 1, bx);
    step(1, 8'hB9, 0, 1, bx);
    @(negedge clk);
    bus.valid_in = 1'b0;
    rst = 1'b1;
    #1;
    check("t5_fill_rst_valid", 32'(bus.valid_out), 0);
    check("t5_fill_rst_keep", 32'(bus.keep_out), 0);
    check("t5_fill_rst_data", bus.data_out, 0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 4; j++) step(1, 8'(8'hC8 + j), 0, 0, bx);
    check("t5_pre_rst_valid", 32'(bus.valid_out), 1);
    #2 rst = 1'b1;
    bus.valid_in = 1'b0;
    #1;
    check("t5_hold_rst_valid", 32'(bus.valid_out), 0);
    check("t5_hold_rst_keep", 32'(bus.keep_out), 0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 4; j++) step(1, 8'(8'hB0 + j), 0, 1, bx);
    check("t5_fresh_word", bus.data_out, 32'hB3B2B1B0);
    check("t5_fresh_keep", 32'(bus.keep_out), 32'hf);
    step(0, 8'h00, 0, 1, bx);
    repeat (65535) step(1, 8'($urandom), 1, 1, bx);
    step(0, 8'h00, 0, 1, bx);
    check("t6_wrap", 32'(bus.word_cnt), 0);
`ifdef BYTE_WORD_PACKER_PARITY_EN
    step(1, 8'h07, 1, 1, bx);
    check("t6_parity", 32'(bus.parity_out), 32'h1);
    step(0, 8'h00, 0, 1, bx);
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
